mult_seq_unit: RTL and testbench

- Iterative radix-2 shift-add multiplier that answers the execute stage's multiply start/done handshake.
- Execute holds `start` high and stalls until `done`. The unit then presents the 64-bit product on `hi`/`lo`.
- Self-contained 33-bit internal adder. Does not borrow the shared ALU.
- Supports MULT (signed) and MULTU (unsigned) via `sgn`.

---
 rtl/mips_pkg.sv | 14 +
 rtl/mult_sign_fix.sv | 34 +++
 rtl/mult_seq_unit.sv | 118 +++++++++++
 tb/tb_mult_seq_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared multiplier constants and sequencer state type.
package mips_pkg;

  localparam int unsigned MULT_WIDTH = 32;
  localparam int unsigned MULT_CNT_W = $clog2(MULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    HOLD = 2'd3
  } mult_state_t;

endpackage

// File: rtl/mult_sign_fix.sv
// Sign handling for the multiplier: operand magnitudes at capture and
// conditional two's-complement negation of the finished product.
module mult_sign_fix
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic               sgn,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               neg,
  input  logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   abs_a_c,
  output logic [WIDTH-1:0]   abs_b_c,
  output logic               neg_c,
  output logic [2*WIDTH-1:0] prod_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic a_neg;
  logic b_neg;

  assign a_neg = sgn & src_a[WIDTH-1];
  assign b_neg = sgn & src_b[WIDTH-1];

  // The most negative value maps onto itself, which reads correctly as unsigned.
  assign abs_a_c = a_neg ? WIDTH'(-src_a) : src_a;
  assign abs_b_c = b_neg ? WIDTH'(-src_b) : src_b;
  assign neg_c   = a_neg ^ b_neg;

  assign prod_c  = neg ? PW'(-prod) : prod;

endmodule

// File: rtl/mult_seq_unit.sv
// Iterative radix-2 shift-add multiplier with start/done handshake.
// Optional MULT_ZERO_BYPASS_EN: zero operands skip straight to HOLD.
module mult_seq_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  mult_state_t      state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] mplier;
  logic             neg;

  logic [WIDTH-1:0] abs_a_c;
  logic [WIDTH-1:0] abs_b_c;
  logic             neg_c;
  logic [PW-1:0]    prod_c;
  logic [WIDTH:0]   sum_c;

`ifdef MULT_ZERO_BYPASS_EN
  logic zero_op_c;
  assign zero_op_c = (src_a == '0) || (src_b == '0);
`endif

  mult_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .sgn     (sgn),
    .src_a   (src_a),
    .src_b   (src_b),
    .neg     (neg),
    .prod    ({acc_hi, mplier}),
    .abs_a_c (abs_a_c),
    .abs_b_c (abs_b_c),
    .neg_c   (neg_c),
    .prod_c  (prod_c)
  );

  // 33-bit partial-sum adder; carry becomes the top bit after the shift.
  assign sum_c = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : (WIDTH+1)'(0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            mcand  <= abs_a_c;
            mplier <= abs_b_c;
            neg    <= neg_c;
            acc_hi <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
`ifdef MULT_ZERO_BYPASS_EN
            if (zero_op_c) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              hi    <= '0;
              lo    <= '0;
              state <= HOLD;
            end
`endif
          end
        end
        RUN: begin
          acc_hi <= sum_c[WIDTH:1];
          mplier <= {sum_c[0], mplier[WIDTH-1:1]};
          count  <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          {hi, lo} <= prod_c;
          busy     <= 1'b0;
          done     <= start;
          state    <= HOLD;
        end
        HOLD: begin
          // Only a low start returns to IDLE, so a held start never retriggers.
          done <= start;
          if (!start) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_unit.sv
// Self-checking bench for mult_seq_unit against an arithmetic product model.
module tb_mult_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;

  mult_seq_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa;
    longint sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one operation with start held; returns once done is seen (or timeout).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit scramble, output logic [63:0] exp);
    int cyc;
    int exp_cyc;
    bit busy_all;
    exp     = ref_mul(a, b, s);
    exp_cyc = 33;
`ifdef MULT_ZERO_BYPASS_EN
    if (a == 32'd0 || b == 32'd0) exp_cyc = 0;
`endif
    src_a = a;
    src_b = b;
    sgn   = s;
    start = 1'b1;
    step();
    check("busy_capture", 64'(busy), (exp_cyc == 0) ? 64'd0 : 64'd1);
    if (scramble) begin
      src_a = 32'hDEADBEEF;
      src_b = 32'hDEADBEEF;
      sgn   = ~s;
    end
    cyc = 0;
    busy_all = 1'b1;
    while (!done && cyc < 100) begin
      step();
      cyc++;
      if (!done && !busy) busy_all = 1'b0;
    end
    check("latency", 64'(cyc), 64'(exp_cyc));
    check("busy_run", 64'(busy_all), 64'd1);
    check("busy_done", 64'(busy), 64'd0);
    check("product", {hi, lo}, exp);
  endtask

  task automatic release_op();
    start = 1'b0;
    step();
    check("done_release", 64'(done), 64'd0);
    check("busy_release", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] exp;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] corners [4];
    corners[0] = 32'd0;
    corners[1] = 32'd1;
    corners[2] = 32'h80000000;
    corners[3] = 32'hFFFFFFFF;

    rst = 1'b0; start = 1'b0; sgn = 1'b0; src_a = '0; src_b = '0;
    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_prod", {hi, lo}, 64'd0);
    rst = 1'b1;
    step();

    // Unsigned all-ones squared
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, exp);
    check("umax_hi", 64'(hi), 64'hFFFFFFFE);
    check("umax_lo", 64'(lo), 64'h00000001);
    release_op();

    // Signed mixes
    run_op(32'hFFFFFFFD, 32'd7, 1'b1, 1'b0, exp);
    check("neg21", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    release_op();
    run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0, exp);
    check("minsq", {hi, lo}, 64'h40000000_00000000);

    // start held in HOLD: no retrigger, result stable
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_done", 64'(done), 64'd1);
      check("hold_prod", {hi, lo}, exp);
    end
    release_op();
    run_op(32'd6, 32'd7, 1'b0, 1'b0, exp);
    check("six_seven", {hi, lo}, 64'd42);
    release_op();

    // Reset in the middle of RUN
    src_a = 32'h12345678; src_b = 32'h9ABCDEF0; sgn = 1'b0; start = 1'b1;
    step();
    repeat (15) step();
    rst = 1'b0; start = 1'b0;
    step();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_prod", {hi, lo}, 64'd0);
    rst = 1'b1;
    step();
    check("midrst_idle", 64'(done), 64'd0);
    run_op(32'd2, 32'd3, 1'b0, 1'b0, exp);
    check("two_three", {hi, lo}, 64'd6);
    release_op();

    // Operand and sgn changes after capture are ignored
    run_op(32'd5, 32'd9, 1'b0, 1'b1, exp);
    check("scramble", {hi, lo}, 64'd45);
    release_op();

    // Zero operand
    run_op(32'd0, 32'h1234, 1'b0, 1'b0, exp);
    check("zero", {hi, lo}, 64'd0);
    release_op();

    // Randomized operations with occasional corner operands
    for (int n = 0; n < 16; n++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = corners[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) rb = corners[$urandom_range(0, 3)];
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0, exp);
      release_op();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
